// File: rtl/score_display_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_pkg
//  Description : Shared types and constants for the score display controller:
//                FSM state encoding, BCD digit type, blank segment code and a
//                power-of-ten helper used to size the saturation limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // Active-low: every segment off.
    localparam logic [6:0] SS_BLANK = 7'b1111111;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_display_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : score_display_ctrl_if
//  Description : Load/value request and display status bundle. The master
//                side issues conversion requests; the slave side (the
//                controller) reports busy/done/overflow and the segment codes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface score_display_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
);
    logic                  load;
    logic [WIDTH-1:0]      value;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [7*DIGITS-1:0]   ss;

    modport master (
        output load, value,
        input  busy, done, overflow, ss
    );

    modport slave (
        input  load, value,
        output busy, done, overflow, ss
    );
endinterface
`default_nettype wire

// File: rtl/score_display_ctrl_hexss.sv
`default_nettype none
// ============================================================================
//  Module      : hexss
//  Description : Hex digit to active-low 7-segment decoder.
//                Segment order o_seg = {g,f,e,d,c,b,a}.
//  Revision    : 1.0 - initial release
// ============================================================================
module hexss
    import score_pkg::*;
(
    input  bcd_digit_t  i_hex,
    output logic [6:0]  o_seg
);

    // Pure lookup of the segment pattern for one nibble.
    always_comb begin
        o_seg = SS_BLANK;
        case (i_hex)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = SS_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/score_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : score_display_ctrl
//  Description : Converts a binary score to BCD with a serial double-dabble
//                (one step per clock) and drives DIGITS active-low 7-segment
//                digits. Values above 10^DIGITS-1 saturate and flag overflow.
//                Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  wire logic           clk,
    input  wire logic           reset,
    score_display_ctrl_if.slave bus
);

    localparam logic [31:0]         c_MAX      = 32'(pow10(DIGITS) - 1);
    localparam int                  c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_bin;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [4*DIGITS-1:0]    r_disp;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overflow;

    logic [31:0]            w_value_ext;
    logic                   w_over;
    logic [WIDTH-1:0]       w_sat;
    logic [4*DIGITS-1:0]    w_bcd_adj;
    logic [7*DIGITS-1:0]    w_seg;
    logic [7*DIGITS-1:0]    w_ss;

    assign w_value_ext = 32'(bus.value);
    assign w_over      = (w_value_ext > c_MAX);
    // When saturating, c_MAX < value < 2^WIDTH, so the truncation is lossless.
    assign w_sat       = w_over ? c_MAX[WIDTH-1:0] : bus.value;

    // Double-dabble correction: add 3 to every nibble >= 5 before shifting.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5)
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    // Control FSM; UPDATE spends one cycle latching digits and one cycle
    // presenting done so that busy and done drop on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_disp     <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_bin      <= w_sat;
                        r_overflow <= w_over;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_bcd <= {w_bcd_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
                    r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST)
                        r_state <= UPDATE;
                end
                UPDATE: begin
                    if (!r_done) begin
                        r_disp <= r_bcd;
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            hexss u_hexss (
                .i_hex (r_disp[4*g +: 4]),
                .o_seg (w_seg[7*g +: 7])
            );
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // Blank each digit above the most significant non-zero one; digit 0 stays.
    always_comb begin
        logic w_zero_above;
        w_zero_above = 1'b1;
        w_ss         = w_seg;
        for (int d = DIGITS - 1; d > 0; d--) begin
            w_zero_above = w_zero_above & (r_disp[4*d +: 4] == 4'd0);
            if (w_zero_above)
                w_ss[7*d +: 7] = SS_BLANK;
        end
    end
`else
    assign w_ss = w_seg;
`endif

    assign bus.ss       = w_ss;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_display_ctrl
//  Description : Self-checking bench for score_display_ctrl (DIGITS=4,
//                WIDTH=14). Expected outputs come from a cycle-count model
//                of the request/latency rules plus literal segment patterns.
//                Honours LEADING_ZERO_BLANK_EN for the expected patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display_ctrl;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 14;
    localparam int MAXV   = 9999;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam logic [6:0] SEG7  = 7'b1111000;
    localparam logic [6:0] SEG9  = 7'b0010000;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [27:0] SS_RST = {BLANK, BLANK, BLANK, ZERO};
    localparam logic [27:0] SS_7   = {BLANK, BLANK, BLANK, SEG7};
    localparam logic [27:0] SS_5   = {BLANK, BLANK, BLANK, 7'b0010010};
`else
    localparam logic [27:0] SS_RST = {ZERO, ZERO, ZERO, ZERO};
    localparam logic [27:0] SS_7   = {ZERO, ZERO, ZERO, SEG7};
    localparam logic [27:0] SS_5   = {ZERO, ZERO, ZERO, 7'b0010010};
`endif
    localparam logic [27:0] SS_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    localparam logic [27:0] SS_9999 = {SEG9, SEG9, SEG9, SEG9};

    logic clk = 1'b0;
    logic reset;

    score_display_ctrl_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

    score_display_ctrl #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // Display pattern for a decimal number, digit by digit.
    function automatic logic [7*DIGITS-1:0] exp_ss(input int v);
        logic [7*DIGITS-1:0] r;
        int p;
        p = 1;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && v < p) r[7*i +: 7] = BLANK;
            else                r[7*i +: 7] = seg_of((v / p) % 10);
`else
            r[7*i +: 7] = seg_of((v / p) % 10);
`endif
            p = p * 10;
        end
        return r;
    endfunction

    // Model: an accepted request shows its saturated value WIDTH+1 edges
    // later for one cycle; requests during the active window are dropped.
    bit m_valid  = 1'b0;
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_ovf    = 1'b0;
    int m_cnt    = 0;
    int m_val    = 0;
    int m_disp   = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_ovf    = 1'b0;
            m_disp   = 0;
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt == WIDTH + 1) begin
                m_disp = m_val;
                m_done = 1'b1;
            end else if (m_cnt == WIDTH + 2) begin
                m_done   = 1'b0;
                m_active = 1'b0;
            end
        end else if (bus.load) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_ovf    = (int'(bus.value) > MAXV);
            m_val    = (int'(bus.value) > MAXV) ? MAXV : int'(bus.value);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",     64'(bus.busy),     64'(m_active));
            chk("done",     64'(bus.done),     64'(m_done));
            chk("overflow", 64'(bus.overflow), 64'(m_ovf));
            chk("ss",       64'(bus.ss),       64'(exp_ss(m_disp)));
        end
    end

    task automatic do_load(input int v);
        bus.load  = 1'b1;
        bus.value = WIDTH'(v);
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 100; i++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        chk(name, 64'(bus.done), 64'(1));
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        chk(name, 64'(bus.busy), 64'(0));
    endtask

    int vec [9] = '{0, 1, 9, 10, 99, 100, 4095, 9998, 16383};

    initial begin
        int nd;
        reset     = 1'b1;
        bus.load  = 1'b0;
        bus.value = '0;
        repeat (2) @(negedge clk);
        chk("rst_ss",   64'(bus.ss), 64'(SS_RST));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_ovf",  64'(bus.overflow), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Exact latency for 1234
        do_load(1234);
        repeat (14) @(negedge clk);
        chk("lat_early_done", 64'(bus.done), 64'(0));
        chk("lat_early_ss",   64'(bus.ss), 64'(SS_RST));
        @(negedge clk);
        chk("lat_done",   64'(bus.done), 64'(1));
        chk("ss_1234",    64'(bus.ss), 64'(SS_1234));
        chk("ovf_1234",   64'(bus.overflow), 64'(0));
        @(negedge clk);
        chk("lat_done_fall", 64'(bus.done), 64'(0));
        chk("lat_busy_fall", 64'(bus.busy), 64'(0));

        // Saturation and overflow persistence
        do_load(12000);
        wait_done("done_12000");
        chk("ss_12000",  64'(bus.ss), 64'(SS_9999));
        chk("ovf_12000", 64'(bus.overflow), 64'(1));
        repeat (5) @(negedge clk);
        chk("ovf_hold",  64'(bus.overflow), 64'(1));

        // Boundary: exactly the maximum displayable value
        do_load(9999);
        chk("ovf_9999_clear", 64'(bus.overflow), 64'(0));
        wait_done("done_9999");
        chk("ss_9999", 64'(bus.ss), 64'(SS_9999));
        @(negedge clk);
        do_load(10000);
        wait_done("done_10000");
        chk("ovf_10000", 64'(bus.overflow), 64'(1));
        @(negedge clk);

        // Second request while busy is dropped
        do_load(5);
        @(negedge clk);
        do_load(7);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("drop_pulses", 64'(nd), 64'(1));
        chk("drop_ss",     64'(bus.ss), 64'(SS_5));
        chk("drop_ovf",    64'(bus.overflow), 64'(0));

        // Leading-zero handling
        do_load(7);
        wait_done("done_7");
        chk("ss_7", 64'(bus.ss), 64'(SS_7));
        @(negedge clk);
        do_load(0);
        wait_done("done_0");
        chk("ss_0", 64'(bus.ss), 64'(SS_RST));
        @(negedge clk);

        // Directed value sweep, checked by the model
        foreach (vec[k]) begin
            do_load(vec[k]);
            wait_done("done_vec");
            @(negedge clk);
        end

        // load held high: re-accepted only once idle
        bus.load  = 1'b1;
        bus.value = WIDTH'(42);
        repeat (40) @(negedge clk);
        bus.load  = 1'b0;
        wait_idle("idle_after_hold");
        @(negedge clk);

        // Reset five cycles into CONVERT aborts the conversion
        do_load(1234);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        chk("abort_ss",   64'(bus.ss), 64'(SS_RST));
        chk("abort_ovf",  64'(bus.overflow), 64'(0));
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(nd), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of decimal digits displayed, legal range 1..6.
REQ-002 SHALL have parameter WIDTH, default 14: width of the binary score input, legal range 4..20.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port load, input, 1 bit: request to convert and display value, sampled on the rising edge.
REQ-006 SHALL have port value, input, WIDTH bits: unsigned binary score.
REQ-007 SHALL have port busy, output, 1 bit: conversion in progress; load is ignored while busy is high.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when new digits appear on ss.
REQ-009 SHALL have port overflow, output, 1 bit: high when the last accepted value exceeded 10^DIGITS-1.
REQ-010 SHALL have port ss, output, 7*DIGITS bits: active-low segment codes, digit 0 (least significant) in bits [6:0].

Function
REQ-011 SHALL implement FSM states IDLE, CONVERT and UPDATE.
REQ-012 IDLE, load=1: SHALL capture min(value, 10^DIGITS-1), set overflow=(value>10^DIGITS-1), clear the BCD shift register, and move to CONVERT.
REQ-013 IDLE, load=0: SHALL hold all state.
REQ-014 CONVERT SHALL run exactly WIDTH double-dabble steps, one per cycle; each step first adds 3 to every BCD nibble >=5, then shifts {BCD,binary} left one bit.
REQ-015 After the WIDTH-th step SHALL move to UPDATE; UPDATE SHALL copy the BCD register into the display-digit register, assert done, and return to IDLE on the next edge.
REQ-016 Latency: done SHALL be high for exactly one cycle, beginning WIDTH+1 rising edges after the edge that sampled load; ss SHALL change in the same cycle done rises.
REQ-017 busy SHALL be high in CONVERT and UPDATE and low in IDLE; done and busy SHALL fall together.
REQ-018 load SHALL be accepted only in IDLE; load in CONVERT or UPDATE SHALL be dropped, not queued.
REQ-019 ss SHALL be a combinational decode of the display-digit register and SHALL hold its value between updates.
REQ-020 BCD register width SHALL be 4*DIGITS bits; the saturated input guarantees no nibble exceeds 9.
REQ-021 overflow SHALL change only on an accepted load.

Reset
REQ-022 reset=1 at a rising edge SHALL force state IDLE, busy=0, done=0, overflow=0, BCD and display digits to 0, regardless of state.
REQ-023 reset during CONVERT or UPDATE SHALL abort the conversion with no done pulse and no display update.
REQ-024 reset SHALL take priority over load in the same cycle.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL drive every digit above the most significant non-zero digit to 7'b1111111; digit 0 is never blanked.
REQ-026 Without LEADING_ZERO_BLANK_EN, SHALL decode every digit, leading zeros showing 7'b1000000.

Structure
REQ-027 Package score_pkg SHALL hold the FSM state enum typedef, a 4-bit BCD digit typedef and the constant SS_BLANK = 7'b1111111.
REQ-028 SHALL instantiate sub-module hexss (the team's hex-to-7-segment decoder) once per digit via a generate loop; no other sub-modules.

Verification
REQ-029 Reset, macro off -> every ss digit 7'b1000000; busy=0, done=0, overflow=0.
REQ-030 Load value=1234 (DIGITS=4, WIDTH=14) -> done exactly 15 edges later; ss digits 3..0 = 1111001, 0100100, 0110000, 0011001; overflow=0.
REQ-031 Load value=12000 -> all four digits 0010000 (9999); overflow=1 until the next accepted load.
REQ-032 Load 5, then load 7 two cycles later -> only one done pulse; display shows 5; the second request is dropped.
REQ-033 Macro on, load 7 -> digits 3..1 = 1111111, digit 0 = 1111000; then load 0 -> digit 0 = 1000000, others blank.
REQ-034 Reset asserted 5 cycles into CONVERT -> no done pulse, busy=0 next cycle, display returns to 0.
